// File: rtl/dimmer_pkg.sv
// Shared definitions for the LED dimmer control stage: duty word width
// and the mode encodings that are also exported on the mode output.
package dimmer_pkg;

   localparam int DUTY_W = 4;
   localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;

   typedef enum logic [1:0] {
      MODE_MANUAL       = 2'd0,
      MODE_BREATHE_UP   = 2'd1,
      MODE_BREATHE_DOWN = 2'd2,
      MODE_INVALID      = 2'd3
   } mode_e;

endpackage

// File: rtl/led_dimmer_ctrl_if.sv
// Button inputs and duty/mode outputs of the dimmer control stage.
// The slave side is the controller; the master side drives the buttons
// and observes the duty word.
interface led_dimmer_ctrl_if;

   logic                          btn_up;
   logic                          btn_down;
   logic                          btn_mode;
   logic [dimmer_pkg::DUTY_W-1:0] duty_cycle;
   logic [1:0]                    mode;
   logic                          step_tick;

   modport master (
      output btn_up, btn_down, btn_mode,
      input  duty_cycle, mode, step_tick
   );

   modport slave (
      input  btn_up, btn_down, btn_mode,
      output duty_cycle, mode, step_tick
   );

endinterface

// File: rtl/btn_conditioner.sv
// One push-button channel: two-flop synchroniser, restartable debounce
// counter and a rising-edge detector on the debounced level.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_reg;
   logic             s2_reg;
   logic             stable_reg;
   logic             stable_d_reg;
   logic [CNT_W-1:0] cnt_reg;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
      end else begin
         s1_reg <= btn_raw;
         s2_reg <= s1_reg;
      end
   end

   // Accept a new level only after it has differed from the current one
   // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_reg <= 1'b0;
         cnt_reg    <= '0;
      end else if (s2_reg == stable_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
         stable_reg <= s2_reg;
         cnt_reg    <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Delayed copy of the debounced level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_d_reg <= 1'b0;
      end else begin
         stable_d_reg <= stable_reg;
      end
   end

   assign level = stable_reg;
   assign press = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/led_dimmer_ctrl.sv
// Dimmer control: conditions three buttons and runs the manual/breathe
// FSM that owns the 4-bit duty word feeding the PWM generator.
module led_dimmer_ctrl
   import dimmer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BREATHE_DIV     = 3125000,
   parameter int INIT_DUTY       = 0
) (
   input logic               clk,
   input logic               reset_n,
   led_dimmer_ctrl_if.slave  bus
);

   localparam int BCNT_W = (BREATHE_DIV > 1) ? $clog2(BREATHE_DIV) : 1;
   localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BREATHE_DIV - 1);

   // Channel order: 0 up, 1 down, 2 mode.
   logic [2:0] btn_raw;
   logic [2:0] btn_press;
   logic [2:0] level_unused;

   assign btn_raw = {bus.btn_mode, bus.btn_down, bus.btn_up};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         btn_conditioner #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_btn (
            .clk     (clk),
            .reset_n (reset_n),
            .btn_raw (btn_raw[gi]),
            .level   (level_unused[gi]),
            .press   (btn_press[gi])
         );
      end
   endgenerate

   logic press_up;
   logic press_down;
   logic press_mode;

   assign press_up   = btn_press[0];
   assign press_down = btn_press[1];
   assign press_mode = btn_press[2];

   mode_e              mode_reg, mode_next;
   logic [DUTY_W-1:0]  duty_reg, duty_next;
   logic [BCNT_W-1:0]  bcnt_reg, bcnt_next;
   logic               step_reg, step_next;
   logic               breathe_tick;

   assign breathe_tick = ((mode_reg == MODE_BREATHE_UP) || (mode_reg == MODE_BREATHE_DOWN))
                         && (bcnt_reg == BCNT_LAST);

   // State, duty word, breathe divider and step pulse registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_reg <= MODE_MANUAL;
         duty_reg <= DUTY_W'(INIT_DUTY);
         bcnt_reg <= '0;
         step_reg <= 1'b0;
      end else begin
         mode_reg <= mode_next;
         duty_reg <= duty_next;
         bcnt_reg <= bcnt_next;
         step_reg <= step_next;
      end
   end

   // Next state: mode press beats up/down presses, which beat breathe ticks.
   always_comb begin
      mode_next = mode_reg;
      duty_next = duty_reg;
      bcnt_next = bcnt_reg;
      step_next = 1'b0;
      case (mode_reg)
         MODE_MANUAL: begin
            // Divider idles at zero so breathe always starts a full period.
            bcnt_next = '0;
            if (press_mode) begin
               mode_next = MODE_BREATHE_UP;
            end else if (press_up && !press_down && (duty_reg != DUTY_MAX)) begin
               duty_next = duty_reg + 1'b1;
               step_next = 1'b1;
            end else if (press_down && !press_up && (duty_reg != '0)) begin
               duty_next = duty_reg - 1'b1;
               step_next = 1'b1;
            end
         end
         MODE_BREATHE_UP, MODE_BREATHE_DOWN: begin
            bcnt_next = breathe_tick ? '0 : bcnt_reg + 1'b1;
            if (press_mode) begin
               mode_next = MODE_MANUAL;
               bcnt_next = '0;
            end else if (breathe_tick) begin
               step_next = 1'b1;
               if (mode_reg == MODE_BREATHE_UP) begin
                  if (duty_reg == DUTY_MAX) begin
                     mode_next = MODE_BREATHE_DOWN;
                     duty_next = DUTY_MAX - 1'b1;
                  end else begin
                     duty_next = duty_reg + 1'b1;
                  end
               end else begin
                  if (duty_reg == '0) begin
                     mode_next = MODE_BREATHE_UP;
                     duty_next = DUTY_W'(1);
                  end else begin
                     duty_next = duty_reg - 1'b1;
                  end
               end
            end
         end
         default: begin
            mode_next = MODE_MANUAL;
            bcnt_next = '0;
         end
      endcase
   end

   assign bus.duty_cycle = duty_reg;
   assign bus.mode       = mode_reg;
   assign bus.step_tick  = step_reg;

endmodule

// File: doc/led_dimmer_ctrl.md
Name: led_dimmer_ctrl

Overview:
Upstream control stage for the PWM LED dimmer. It conditions three raw board push-buttons (synchronise, debounce, edge-detect) and maintains the 4-bit duty_cycle word that drives the PWM generator's duty_cycle input directly. It supports a manual up/down mode and an automatic "breathe" mode that ramps the duty cycle 0→15→0 continuously.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); minimum 2.
BREATHE_DIV, 3125000, clock cycles between duty steps in breathe mode; minimum 2.
INIT_DUTY, 0, duty_cycle value after reset (0..15).

Ports:
clk  in  1  system clock, rising-edge
reset_n  in  1  asynchronous active-low reset
btn_up  in  1  raw push-button, asynchronous, active-high
btn_down  in  1  raw push-button, asynchronous, active-high
btn_mode  in  1  raw push-button, asynchronous, active-high
duty_cycle  out  4  duty word to the PWM stage, registered
mode  out  2  FSM state: 0 MANUAL, 1 BREATHE_UP, 2 BREATHE_DOWN
step_tick  out  1  one-cycle pulse on every cycle in which duty_cycle is updated

Behaviour:
- Reset (reset_n low, asynchronous): duty_cycle=INIT_DUTY, mode=MANUAL, step_tick=0. All synchroniser flops, debounced levels, debounce counters, delayed levels and breathe counter are cleared to 0. Release takes effect on the next clk edge.
- Per button, identical channel:
  - 2-flop synchroniser (s1, s2).
  - Debounce counter cnt (width clog2(DEBOUNCE_CYCLES)).
    - If s2==stable: cnt<=0.
    - Else if cnt==DEBOUNCE_CYCLES-1: stable<=s2, cnt<=0.
    - Else: cnt<=cnt+1.
  - Registered copy stable_d. press = stable & ~stable_d, combinational, high for exactly one cycle per accepted press. Release produces no event.
- Latency: raw input first sampled high at edge 0 and held → stable rises at edge DEBOUNCE_CYCLES+1 → duty_cycle/mode update at edge DEBOUNCE_CYCLES+2.
- Any bounce (s2 returning to stable) before the count completes restarts the count from 0.
- FSM, evaluated on every edge with priority mode press > up/down press > breathe tick:
  - MANUAL:
    - mode press → BREATHE_UP; breathe counter cleared; duty held.
    - up press alone: duty+1, saturating at 15.
    - down press alone: duty-1, saturating at 0.
    - up and down press in the same cycle: no change.
  - BREATHE_UP / BREATHE_DOWN:
    - mode press → MANUAL; duty held at its current value.
    - up/down presses ignored.
    - Breathe counter counts 0..BREATHE_DIV-1 and wraps; tick when it equals BREATHE_DIV-1.
    - BREATHE_UP on tick: if duty==15 → BREATHE_DOWN, duty=14; else duty+1.
    - BREATHE_DOWN on tick: if duty==0 → BREATHE_UP, duty=1; else duty-1.
  - mode press in the same cycle as a tick: the mode change wins and the tick's step is discarded.
  - Encoding 3 is unreachable; if reached, the next edge goes to MANUAL with duty held.
- step_tick: registered, high in the cycle after any edge that changed duty_cycle by a step. It is not asserted for saturated or blocked presses.
- Reset mid-operation (mid-debounce or mid-ramp): all state is discarded immediately. No press event is generated from a partially counted button.
- duty_cycle changes only on clk edges, never glitches, and holds between updates. The PWM stage samples it with no handshake.

Decomposition:
- Shared package dimmer_pkg: mode encodings MODE_MANUAL/MODE_BREATHE_UP/MODE_BREATHE_DOWN, DUTY_W=4, DUTY_MAX=15.
- Sub-module btn_conditioner (parameter DEBOUNCE_CYCLES; ports clk, reset_n, btn_raw, level, press), instantiated three times. FSM and breathe divider stay in the top.

Test Plan:
(Bench overrides DEBOUNCE_CYCLES=4, BREATHE_DIV=8, INIT_DUTY=0.)
- Reset check: reset_n low with buttons idle → duty_cycle=0, mode=0, step_tick=0. Assert reset mid-cycle → outputs clear before the next edge.
- Clean press: btn_up held 10 cycles from edge 0 → duty_cycle becomes 1 at edge 6 and step_tick pulses once. Release and 3 more presses → duty_cycle=4.
- Bounce: btn_up toggles high 2 cycles / low 1 cycle ×5, then held high → exactly one increment, occurring 6 edges after the final rising sample.
- Saturation: 17 up presses from 0 → duty stays 15, step_tick absent on presses 16–17. 17 down presses → duty=0. Simultaneous up+down press at duty=7 → remains 7.
- Breathe: mode press at duty=14 → mode=1; after 8 cycles duty=15; next tick mode=2, duty=14; ramp to 0, then mode=1, duty=1. Up presses during the ramp are ignored.
- Exit and collision: mode press coinciding with a breathe tick at duty=9 → mode=0, duty=9 held. A subsequent up press → duty=10.
